// File: rtl/alu_issue_unit.sv
// alu_issue_unit: registered front end for the combinational 16-bit ALU.
// Accepts commands over a valid/ready handshake. It drives registered
// opcode and operands to the ALU, captures the ALU result one cycle later,
// and returns it over a second valid/ready handshake.
// Optional feature: define ALU_ISSUE_ACC_EN to add an accumulator that can
// replace operand A.
module alu_issue_unit #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [WIDTH-1:0]     cmd_a,
   input  logic [WIDTH-1:0]     cmd_b,
   input  logic                 cmd_use_acc,
   output logic [2:0]           alu_op,
   output logic [WIDTH-1:0]     alu_in0,
   output logic [WIDTH-1:0]     alu_in1,
   input  logic [WIDTH-1:0]     alu_dout,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [WIDTH-1:0]     res_data,
   output logic                 res_zero,
   output logic [CNT_WIDTH-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             deliver;
   logic [WIDTH-1:0] operand_a;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)  state_next = EXEC;
         EXEC:                 state_next = RESP;
         RESP:    if (deliver) state_next = IDLE;
         default:              state_next = IDLE;
      endcase
   end

   // Handshake decode; cmd_ready is gated by rst so it reads low during reset
   always_comb begin
      cmd_ready = (state == IDLE) && !rst;
      accept    = cmd_valid && cmd_ready;
      deliver   = (state == RESP) && res_valid && res_ready;
   end

`ifdef ALU_ISSUE_ACC_EN
   logic [WIDTH-1:0] acc;

   // Accumulator follows every ALU result
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 acc <= '0;
      else if (state == EXEC)  acc <= alu_dout;
   end

   // Operand A source select
   always_comb begin
      operand_a = cmd_use_acc ? acc : cmd_a;
   end
`else
   logic unused_use_acc;

   // Operand A always comes from the command; the accumulator select is ignored
   always_comb begin
      operand_a      = cmd_a;
      unused_use_acc = cmd_use_acc;
   end
`endif

   // ALU input registers: load only on command acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op  <= '0;
         alu_in0 <= '0;
         alu_in1 <= '0;
      end else if (accept) begin
         alu_op  <= cmd_op;
         alu_in0 <= operand_a;
         alu_in1 <= cmd_b;
      end
   end

   // Result capture and hold until handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_zero  <= 1'b0;
      end else if (state == EXEC) begin
         res_valid <= 1'b1;
         res_data  <= alu_dout;
         res_zero  <= (alu_dout == '0);
      end else if (deliver) begin
         res_valid <= 1'b0;
      end
   end

   // Completed-operation counter, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          op_count <= '0;
      else if (deliver) op_count <= op_count + 1'b1;
   end

endmodule
